// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, depth and threshold helpers for sync_fifo_param
package fifo_pkg;

  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH      = 8;
  localparam int DEF_ALMOST_FULL_TH  = 240;
  localparam int DEF_ALMOST_EMPTY_TH = 16;

  typedef enum logic {
    RD_NORMAL     = 1'b0,
    RD_SHOW_AHEAD = 1'b1
  } rd_mode_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic bit th_in_range(input int th, input int addr_width);
    return (th >= 1) && (th <= fifo_depth(addr_width));
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  wrreq;
  logic                  rdreq;
  logic [DATA_WIDTH-1:0] q;
  logic [ADDR_WIDTH:0]   usedw;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output data, wrreq, rdreq,
    input  q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
  );

  modport slave (
    input  data, wrreq, rdreq,
    output q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_dp.sv
// rtl/fifo_mem_dp.sv - simple dual-port register array, sync write, async read
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Contents are deliberately never reset; the parent's pointers define validity.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with occupancy, level and sticky error flags
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
  parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH,
  parameter int SHOW_AHEAD      = 0
) (
  input  logic              clock,
  input  logic              sclr,
  sync_fifo_param_if.slave  fif
);

  localparam int                  DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_W    = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_W    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
  localparam rd_mode_e            RD_MODE = (SHOW_AHEAD != 0) ? RD_SHOW_AHEAD : RD_NORMAL;

  if (!th_in_range(ALMOST_FULL_TH, ADDR_WIDTH)) begin : g_bad_af_th
    $error("sync_fifo_param: ALMOST_FULL_TH must lie in 1..DEPTH");
  end
  if (!th_in_range(ALMOST_EMPTY_TH, ADDR_WIDTH)) begin : g_bad_ae_th
    $error("sync_fifo_param: ALMOST_EMPTY_TH must lie in 1..DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   usedw_q, usedw_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign empty = (usedw_q == '0);
  assign full  = (usedw_q == DEPTH_W);

  always_comb begin
    rd_ok       = fif.rdreq & ~empty;
    // A read in the same cycle frees the slot, so a full FIFO still takes the write.
    wr_ok       = fif.wrreq & (~full | rd_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    usedw_d     = usedw_q;
    overflow_d  = overflow_q | (fif.wrreq & full & ~rd_ok);
    underflow_d = underflow_q | (fif.rdreq & empty);
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({wr_ok, rd_ok})
      2'b10:   usedw_d = usedw_q + (ADDR_WIDTH+1)'(1);
      2'b01:   usedw_d = usedw_q - (ADDR_WIDTH+1)'(1);
      default: usedw_d = usedw_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      usedw_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      usedw_q     <= usedw_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock (clock),
    .we    (wr_ok),
    .waddr (wr_ptr_q),
    .wdata (fif.data),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (RD_MODE == RD_SHOW_AHEAD) begin : g_show_ahead
    assign fif.q = mem_rdata;
  end else begin : g_normal
    logic [DATA_WIDTH-1:0] q_q, q_d;

    always_comb begin
      q_d = q_q;
      if (rd_ok) begin
        q_d = mem_rdata;
      end
    end

    always_ff @(posedge clock) begin
      if (sclr) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end

    assign fif.q = q_q;
  end

  assign fif.usedw        = usedw_q;
  assign fif.empty        = empty;
  assign fif.full         = full;
  assign fif.almost_empty = (usedw_q < AE_W);
  assign fif.almost_full  = (usedw_q >= AF_W);
  assign fif.overflow     = overflow_q;
  assign fif.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param, normal and show-ahead
module tb_sync_fifo_param;

  logic clock = 1'b0;
  logic sclr;

  sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_n ();
  sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus_s ();

  sync_fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .ALMOST_FULL_TH(240), .ALMOST_EMPTY_TH(16), .SHOW_AHEAD(0)
  ) u_dut_n (
    .clock (clock),
    .sclr  (sclr),
    .fif   (bus_n)
  );

  sync_fifo_param #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .ALMOST_FULL_TH(240), .ALMOST_EMPTY_TH(16), .SHOW_AHEAD(1)
  ) u_dut_s (
    .clock (clock),
    .sclr  (sclr),
    .fif   (bus_s)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  int         m_cnt;
  bit         m_ovf, m_unf;
  logic [7:0] m_q;
  logic [7:0] sb[$];

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] d;
    int         usedw;
    bit         empty;
    bit         unf;
    logic [7:0] q;
  } vec_t;

  vec_t vt[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_status();
    return 32'({bus_n.usedw, bus_n.empty, bus_n.full, bus_n.almost_empty,
                bus_n.almost_full, bus_n.overflow, bus_n.underflow});
  endfunction

  function automatic logic [31:0] exp_status();
    return 32'({9'(m_cnt), m_cnt == 0, m_cnt == 256, m_cnt < 16, m_cnt >= 240, m_ovf, m_unf});
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One clock on the normal-mode DUT; the scoreboard predicts acceptance and q.
  task automatic cyc(input bit wr, input bit rd, input logic [7:0] d, input bit clr);
    bit rd_ok, wr_ok;
    bus_n.wrreq = wr;
    bus_n.rdreq = rd;
    bus_n.data  = d;
    sclr        = clr;
    if (clr) begin
      m_cnt = 0; m_ovf = 1'b0; m_unf = 1'b0; m_q = 8'h00;
      sb.delete();
    end else begin
      rd_ok = rd && (m_cnt > 0);
      wr_ok = wr && ((m_cnt < 256) || rd_ok);
      if (wr && (m_cnt == 256) && !rd_ok) m_ovf = 1'b1;
      if (rd && (m_cnt == 0)) m_unf = 1'b1;
      if (rd_ok) m_q = sb.pop_front();
      if (wr_ok) sb.push_back(d);
      m_cnt = m_cnt + int'(wr_ok) - int'(rd_ok);
    end
    tick();
    check("status", dut_status(), exp_status());
    check("q", 32'(bus_n.q), 32'(m_q));
    bus_n.wrreq = 1'b0;
    bus_n.rdreq = 1'b0;
    sclr        = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{wr:1'b0, rd:1'b1, d:8'h00, usedw:0, empty:1'b1, unf:1'b1, q:8'h00};
    vt[1] = '{wr:1'b1, rd:1'b1, d:8'h5A, usedw:1, empty:1'b0, unf:1'b1, q:8'h00};
    vt[2] = '{wr:1'b1, rd:1'b0, d:8'h3C, usedw:2, empty:1'b0, unf:1'b1, q:8'h00};
    vt[3] = '{wr:1'b0, rd:1'b1, d:8'h00, usedw:1, empty:1'b0, unf:1'b1, q:8'h5A};
    vt[4] = '{wr:1'b1, rd:1'b1, d:8'h77, usedw:1, empty:1'b0, unf:1'b1, q:8'h3C};
    vt[5] = '{wr:1'b0, rd:1'b1, d:8'h00, usedw:0, empty:1'b1, unf:1'b1, q:8'h77};
    vt[6] = '{wr:1'b0, rd:1'b0, d:8'h00, usedw:0, empty:1'b1, unf:1'b1, q:8'h77};

    sclr        = 1'b0;
    bus_n.wrreq = 1'b0; bus_n.rdreq = 1'b0; bus_n.data = 8'h00;
    bus_s.wrreq = 1'b0; bus_s.rdreq = 1'b0; bus_s.data = 8'h00;

    // Reset state
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_usedw", 32'(bus_n.usedw), 32'd0);
    check("rst_flags", 32'({bus_n.empty, bus_n.full, bus_n.almost_empty, bus_n.almost_full}), 32'b1010);
    check("rst_q", 32'(bus_n.q), 32'h00);

    // Fill to DEPTH-1, then the last word
    for (int i = 0; i < 255; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    check("fill255_usedw", 32'(bus_n.usedw), 32'd255);
    check("fill255_flags", 32'({bus_n.almost_full, bus_n.full, bus_n.empty}), 32'b100);
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    check("full_usedw", 32'(bus_n.usedw), 32'd256);
    check("full_flag_no_ovf", 32'({bus_n.full, bus_n.overflow}), 32'b10);

    // Overflow, then simultaneous write+read while full
    cyc(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_set", 32'({bus_n.overflow, bus_n.usedw}), 32'({1'b1, 9'd256}));
    cyc(1'b1, 1'b1, 8'hAB, 1'b0);
    check("full_wr_rd", 32'({bus_n.overflow, bus_n.usedw, bus_n.q}), 32'({1'b1, 9'd256, 8'h00}));
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("ovf_cleared", 32'(bus_n.overflow), 32'd0);

    // Refill 0..255 and read it all back
    for (int i = 0; i < 256; i++) cyc(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
      check("rd_seq", 32'(bus_n.q), 32'(i));
      if (i == 239) check("ae_at_16", 32'(bus_n.almost_empty), 32'd0);
      if (i == 240) check("ae_at_15", 32'(bus_n.almost_empty), 32'd1);
    end
    check("drained", 32'({bus_n.empty, bus_n.usedw}), 32'({1'b1, 9'd0}));
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    check("q_hold", 32'(bus_n.q), 32'hFF);

    // Table of empty-boundary vectors from a fresh reset
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc(vt[i].wr, vt[i].rd, vt[i].d, 1'b0);
      check($sformatf("vec%0d_usedw", i), 32'(bus_n.usedw), 32'(vt[i].usedw));
      check($sformatf("vec%0d_flags", i), 32'({bus_n.empty, bus_n.underflow}), 32'({vt[i].empty, vt[i].unf}));
      check($sformatf("vec%0d_q", i), 32'(bus_n.q), 32'(vt[i].q));
    end

    // Mid-operation sclr with wrreq discards everything
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 8'(i + 1), 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'hEE, 1'b1);
    check("sclr_state", 32'({bus_n.usedw, bus_n.empty, bus_n.overflow, bus_n.underflow, bus_n.q}),
          32'({9'd0, 1'b1, 1'b0, 1'b0, 8'h00}));

    // Pointer wrap: steady-state write+read pairs well past DEPTH
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 150; i++) begin
      cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
      cyc(1'b0, 1'b1, 8'h00, 1'b0);
    end
    repeat (3) cyc(1'b0, 1'b1, 8'h00, 1'b0);
    check("wrap_drained", 32'(bus_n.empty), 32'd1);

    // Show-ahead instance
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    bus_s.wrreq = 1'b1; bus_s.data = 8'h11;
    tick();
    check("sa_first_q", 32'({bus_s.q, bus_s.empty}), 32'({8'h11, 1'b0}));
    bus_s.data = 8'h22;
    tick();
    bus_s.wrreq = 1'b0;
    tick();
    check("sa_head_no_rd", 32'({bus_s.q, bus_s.usedw}), 32'({8'h11, 9'd2}));
    bus_s.rdreq = 1'b1;
    tick();
    bus_s.rdreq = 1'b0;
    check("sa_advance", 32'({bus_s.q, bus_s.usedw}), 32'({8'h22, 9'd1}));
    bus_s.rdreq = 1'b1;
    tick();
    check("sa_empty", 32'({bus_s.empty, bus_s.underflow}), 32'b10);
    tick();
    bus_s.rdreq = 1'b0;
    check("sa_underflow", 32'({bus_s.empty, bus_s.underflow, bus_s.usedw}), 32'({1'b1, 1'b1, 9'd0}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
